// File: rtl/hud_digit_renderer.sv
// hud_digit_renderer: per-frame double-dabble of score/fuel, drawn as scaled 8x8 digit glyphs
module hud_digit_renderer #(
  parameter int SCORE_X = 549,
  parameter int SCORE_Y = 85,
  parameter int FUEL_X = 549,
  parameter int FUEL_Y = 150,
  parameter int SCALE = 2,
  parameter logic [7:0] FG_COLOR = 8'hff,
  parameter logic [7:0] MASK_VALUE = 8'h62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [10:0] requested_x,
  input  logic [10:0] requested_y,
  input  logic [13:0] score_val,
  input  logic [13:0] fuel_val,
  output logic [7:0]  output_color,
  output logic        conv_busy,
  output logic        fuel_empty
);
  typedef enum logic [1:0] {IDLE, SHIFT_SCORE, SHIFT_FUEL, COMMIT} state_t;
  localparam logic [10:0] CELL = 11'(8 * SCALE);
  localparam logic [10:0] SC = 11'(SCALE);
  localparam logic [10:0] SX0 = 11'(SCORE_X);
  localparam logic [10:0] SX1 = 11'(SCORE_X + 5 * 8 * SCALE);
  localparam logic [10:0] SY0 = 11'(SCORE_Y);
  localparam logic [10:0] SY1 = 11'(SCORE_Y + 8 * SCALE);
  localparam logic [10:0] FX0 = 11'(FUEL_X);
  localparam logic [10:0] FX1 = 11'(FUEL_X + 3 * 8 * SCALE);
  localparam logic [10:0] FY0 = 11'(FUEL_Y);
  localparam logic [10:0] FY1 = 11'(FUEL_Y + 8 * SCALE);
  state_t state;
  logic [13:0] s_bin, f_bin;
  logic [19:0] s_bcd, s_adj, s_disp, s_sh;
  logic [11:0] f_bcd, f_adj, f_disp, f_sh;
  logic [3:0] cnt;
  logic [10:0] sx, sy, fx, fy;
  logic [2:0] si;
  logic [1:0] fi;
  logic in_s, in_f, s_on, f_on;
  function automatic logic glyph(input logic [3:0] d, input logic [2:0] r, input logic [2:0] c);
    logic [63:0] f;
    case (d)
      4'd0: f = 64'h3C666E7666663C00;
      4'd1: f = 64'h1838181818187E00;
      4'd2: f = 64'h3C66060C30607E00;
      4'd3: f = 64'h3C66061C06663C00;
      4'd4: f = 64'h0C1C3C6C7E0C0C00;
      4'd5: f = 64'h7E607C0606663C00;
      4'd6: f = 64'h3C66607C66663C00;
      4'd7: f = 64'h7E660C1818181800;
      4'd8: f = 64'h3C66663C66663C00;
      default: f = 64'h3C66663E06663C00;
    endcase
    return f[{~r, ~c}];
  endfunction
  for (genvar i = 0; i < 5; i++) begin : g_s
    assign s_adj[4*i +: 4] = s_bcd[4*i +: 4] >= 4'd5 ? s_bcd[4*i +: 4] + 4'd3 : s_bcd[4*i +: 4];
  end
  for (genvar i = 0; i < 3; i++) begin : g_f
    assign f_adj[4*i +: 4] = f_bcd[4*i +: 4] >= 4'd5 ? f_bcd[4*i +: 4] + 4'd3 : f_bcd[4*i +: 4];
  end
  // conversion sequencer: latch, 14 score shifts, 14 fuel shifts, atomic commit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      s_bin <= '0;
      f_bin <= '0;
      s_bcd <= '0;
      f_bcd <= '0;
      s_disp <= '0;
      f_disp <= '0;
      cnt <= '0;
      conv_busy <= 1'b0;
      fuel_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          s_bin <= score_val;
          f_bin <= fuel_val > 14'd999 ? 14'd999 : fuel_val;
          s_bcd <= '0;
          f_bcd <= '0;
          cnt <= '0;
          conv_busy <= 1'b1;
          state <= SHIFT_SCORE;
        end
        SHIFT_SCORE: begin
          {s_bcd, s_bin} <= {s_adj, s_bin} << 1;
          cnt <= cnt == 4'd13 ? 4'd0 : cnt + 4'd1;
          if (cnt == 4'd13) state <= SHIFT_FUEL;
        end
        SHIFT_FUEL: begin
          {f_bcd, f_bin} <= {f_adj, f_bin} << 1;
          cnt <= cnt == 4'd13 ? 4'd0 : cnt + 4'd1;
          if (cnt == 4'd13) state <= COMMIT;
        end
        default: begin
          s_disp <= s_bcd;
          f_disp <= f_bcd;
          fuel_empty <= f_bcd == 12'd0;
          conv_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  // box hit test, cell/glyph addressing and leading-zero blanking
  always_comb begin
    in_s = requested_x >= SX0 && requested_x < SX1 && requested_y >= SY0 && requested_y < SY1;
    in_f = requested_x >= FX0 && requested_x < FX1 && requested_y >= FY0 && requested_y < FY1;
    sx = in_s ? requested_x - SX0 : 11'd0;
    sy = in_s ? requested_y - SY0 : 11'd0;
    fx = in_f ? requested_x - FX0 : 11'd0;
    fy = in_f ? requested_y - FY0 : 11'd0;
    si = 3'(sx / CELL);
    fi = 2'(fx / CELL);
    s_sh = s_disp >> {3'd4 - si, 2'b00};
    f_sh = f_disp >> {2'd2 - fi, 2'b00};
    s_on = !(si != 3'd4 && s_sh == 20'd0) && glyph(s_sh[3:0], 3'((sy % CELL) / SC), 3'((sx % CELL) / SC));
    f_on = !(fi != 2'd2 && f_sh == 12'd0) && glyph(f_sh[3:0], 3'((fy % CELL) / SC), 3'((fx % CELL) / SC));
  end
  // registered pixel colour, score box wins on overlap
  always_ff @(posedge clk or posedge reset)
    if (reset) output_color <= MASK_VALUE;
    else output_color <= (in_s ? s_on : in_f && f_on) ? FG_COLOR : MASK_VALUE;
endmodule
